// File: rtl/matrix_pkg.sv
// Shared definitions for the parametrised matrix-multiply engine:
// address map, register bit positions and FSM encoding.
package matrix_pkg;

    localparam int unsigned A_BASE       = 32'h00;
    localparam int unsigned B_BASE       = 32'h10;
    localparam int unsigned C_BASE       = 32'h20;
    localparam int unsigned REG_CTRL     = 32'h30;
    localparam int unsigned REG_STATUS   = 32'h31;
    localparam int unsigned REG_DMA_BASE = 32'h32;
    localparam int unsigned REG_INT_CLR  = 32'h33;

    localparam int CTRL_START  = 0;
    localparam int CTRL_INT_EN = 1;
    localparam int CTRL_DMA_EN = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_DMA  = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MAC     = 3'd1,
        ST_DMA_REQ = 3'd2,
        ST_DMA_WR  = 3'd3,
        ST_FIN     = 3'd4
    } state_e;

    // Row-major position of (row, col) inside a 16-word region.
    function automatic logic [3:0] flat_idx(input logic [1:0] row, input logic [1:0] col,
                                            input int n);
        return 4'(int'(row) * n + int'(col));
    endfunction

endpackage

// File: rtl/matrix_mac_unit.sv
// Multiply-accumulate datapath: one truncated product per enabled cycle,
// accumulator cleared on start and after each dot product completes.
module matrix_mac_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic              last_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] acc_next_o,
    output logic              wr_en_o
);

    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] prod;

    assign prod       = a_i * b_i;
    assign acc_next_o = acc_q + prod;
    assign wr_en_o    = en_i & last_i;

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= last_i ? '0 : acc_next_o;
        end
    end

endmodule

// File: rtl/matrix_mac_dma.sv
// N x N matrix-multiply engine: bus-slave register file, MAC sequencer and
// optional DMA master that streams C to memory on completion.
module matrix_mac_dma
    import matrix_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              S_sel,
    input  logic              S_wr,
    input  logic [ADDR_W-1:0] S_address,
    input  logic [DATA_W-1:0] S_din,
    output logic [DATA_W-1:0] S_dout,
    output logic              M1_req,
    input  logic              M1_grant,
    output logic              M1_wr,
    output logic [ADDR_W-1:0] M1_address,
    output logic [DATA_W-1:0] M1_dout,
    output logic              multi_done,
    output logic              m_interrupt
);

    localparam logic [1:0]        LAST     = 2'(N - 1);
    localparam logic [3:0]        NN_LAST  = 4'(N * N - 1);
    localparam logic [ADDR_W-1:0] NN       = ADDR_W'(N * N);
    localparam logic [ADDR_W-1:0] A_LO     = ADDR_W'(A_BASE);
    localparam logic [ADDR_W-1:0] B_LO     = ADDR_W'(B_BASE);
    localparam logic [ADDR_W-1:0] C_LO     = ADDR_W'(C_BASE);
    localparam logic [ADDR_W-1:0] ADR_CTRL = ADDR_W'(REG_CTRL);
    localparam logic [ADDR_W-1:0] ADR_STAT = ADDR_W'(REG_STATUS);
    localparam logic [ADDR_W-1:0] ADR_BASE = ADDR_W'(REG_DMA_BASE);
    localparam logic [ADDR_W-1:0] ADR_ICLR = ADDR_W'(REG_INT_CLR);

    state_e            state_q;
    logic [DATA_W-1:0] a_q [16];
    logic [DATA_W-1:0] b_q [16];
    logic [DATA_W-1:0] c_q [16];
    logic [1:0]        i_q, j_q, k_q;
    logic [3:0]        idx_q;
    logic              done_q, int_en_q, dma_en_q, irq_q, done_pulse_q, req_q;
    logic [ADDR_W-1:0] dma_base_q, maddr_q;
    logic [DATA_W-1:0] mdout_q, dout_q, rdata_d;

    logic              wr_en, rd_en, idle, busy, dma_active;
    logic              in_a, in_b, in_c;
    logic [ADDR_W-1:0] off_a, off_b, off_c;
    logic              ctrl_we, base_we, iclr_we, start_go;
    logic [DATA_W-1:0] acc_next;
    logic              c_we;

    assign wr_en      = S_sel & S_wr;
    assign rd_en      = S_sel & ~S_wr;
    assign idle       = (state_q == ST_IDLE);
    assign busy       = ~idle;
    assign dma_active = (state_q == ST_DMA_REQ) || (state_q == ST_DMA_WR);

    // Offsets wrap below each base, so a single unsigned compare bounds the region.
    assign off_a = S_address - A_LO;
    assign off_b = S_address - B_LO;
    assign off_c = S_address - C_LO;
    assign in_a  = off_a < NN;
    assign in_b  = off_b < NN;
    assign in_c  = off_c < NN;

    assign ctrl_we  = wr_en && (S_address == ADR_CTRL);
    assign base_we  = wr_en && (S_address == ADR_BASE);
    assign iclr_we  = wr_en && (S_address == ADR_ICLR);
    assign start_go = ctrl_we && S_din[CTRL_START] && idle;

    matrix_mac_unit #(.DATA_W(DATA_W)) u_mac (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (start_go),
        .en_i       (state_q == ST_MAC),
        .last_i     (k_q == LAST),
        .a_i        (a_q[flat_idx(i_q, k_q, N)]),
        .b_i        (b_q[flat_idx(k_q, j_q, N)]),
        .acc_next_o (acc_next),
        .wr_en_o    (c_we)
    );

    always_comb begin
        rdata_d = '0;
        if (in_a) begin
            rdata_d = a_q[off_a[3:0]];
        end else if (in_b) begin
            rdata_d = b_q[off_b[3:0]];
        end else if (in_c) begin
            rdata_d = c_q[off_c[3:0]];
        end else begin
            case (S_address)
                ADR_CTRL: rdata_d = DATA_W'({dma_en_q, int_en_q, 1'b0});
                ADR_STAT: rdata_d = DATA_W'({dma_active, done_q, busy});
                ADR_BASE: rdata_d = DATA_W'(dma_base_q);
                default:  rdata_d = '0;
            endcase
        end
    end

    // Operand registers and the slave read port; operands are frozen while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < 16; n++) begin
                a_q[n] <= '0;
                b_q[n] <= '0;
            end
            dout_q <= '0;
        end else begin
            if (wr_en && idle && in_a) a_q[off_a[3:0]] <= S_din;
            if (wr_en && idle && in_b) b_q[off_b[3:0]] <= S_din;
            if (rd_en) dout_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            i_q          <= '0;
            j_q          <= '0;
            k_q          <= '0;
            idx_q        <= '0;
            done_q       <= 1'b0;
            int_en_q     <= 1'b0;
            dma_en_q     <= 1'b0;
            dma_base_q   <= '0;
            irq_q        <= 1'b0;
            done_pulse_q <= 1'b0;
            req_q        <= 1'b0;
            maddr_q      <= '0;
            mdout_q      <= '0;
            for (int n = 0; n < 16; n++) c_q[n] <= '0;
        end else begin
            done_pulse_q <= 1'b0;
            irq_q        <= done_q & int_en_q;
            if (ctrl_we) begin
                int_en_q <= S_din[CTRL_INT_EN];
                dma_en_q <= S_din[CTRL_DMA_EN];
            end
            if (base_we) dma_base_q <= S_din[ADDR_W-1:0];
            if (iclr_we && S_din[0]) done_q <= 1'b0;
            if (c_we) c_q[flat_idx(i_q, j_q, N)] <= acc_next;

            // FIN is evaluated after INT_CLR so a coincident clear loses to the new done.
            case (state_q)
                ST_IDLE: begin
                    if (start_go) begin
                        done_q  <= 1'b0;
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                        state_q <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (k_q == LAST) begin
                        k_q <= '0;
                        if (j_q == LAST) begin
                            j_q <= '0;
                            if (i_q == LAST) begin
                                i_q <= '0;
                                if (dma_en_q) begin
                                    state_q <= ST_DMA_REQ;
                                    req_q   <= 1'b1;
                                end else begin
                                    state_q <= ST_FIN;
                                end
                            end else begin
                                i_q <= i_q + 2'd1;
                            end
                        end else begin
                            j_q <= j_q + 2'd1;
                        end
                    end else begin
                        k_q <= k_q + 2'd1;
                    end
                end
                ST_DMA_REQ: begin
                    if (M1_grant) begin
                        state_q <= ST_DMA_WR;
                        idx_q   <= '0;
                        maddr_q <= dma_base_q;
                        mdout_q <= c_q[0];
                    end
                end
                ST_DMA_WR: begin
                    if (M1_grant) begin
                        if (idx_q == NN_LAST) begin
                            state_q <= ST_FIN;
                            req_q   <= 1'b0;
                            maddr_q <= '0;
                            mdout_q <= '0;
                        end else begin
                            idx_q   <= idx_q + 4'd1;
                            maddr_q <= maddr_q + ADDR_W'(1);
                            mdout_q <= c_q[idx_q + 4'd1];
                        end
                    end
                end
                ST_FIN: begin
                    done_pulse_q <= 1'b1;
                    done_q       <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign S_dout      = dout_q;
    assign M1_req      = req_q;
    assign M1_wr       = (state_q == ST_DMA_WR) & M1_grant;
    assign M1_address  = maddr_q;
    assign M1_dout     = mdout_q;
    assign multi_done  = done_pulse_q;
    assign m_interrupt = irq_q;

endmodule
